// File: rtl/ysyx_25040118_mem_pkg.sv
// rtl/ysyx_25040118_mem_pkg.sv - shared types and constants for the memory arbiter
package ysyx_25040118_mem_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;
  typedef enum logic {OWN_IFU, OWN_LSU} owner_e;

  localparam int MASK_W = 4;
  localparam logic [MASK_W-1:0] MASK_NONE = 4'b0000;
  localparam logic [MASK_W-1:0] MASK_WORD = 4'b1111;

endpackage

// File: rtl/ysyx_25040118_rr_arb2.sv
// rtl/ysyx_25040118_rr_arb2.sv - two-way round-robin grant with last-grant memory
module ysyx_25040118_rr_arb2
  import ysyx_25040118_mem_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic ifu_req,
  input  logic lsu_req,
  output logic ifu_gnt,
  output logic lsu_gnt
);

  owner_e last_grant_q, last_grant_d;

  // On a tie the requester that did not win last time is favoured.
  always_comb begin
    ifu_gnt = 1'b0;
    lsu_gnt = 1'b0;
    if (en) begin
      if (ifu_req && lsu_req) begin
        ifu_gnt = (last_grant_q == OWN_LSU);
        lsu_gnt = (last_grant_q == OWN_IFU);
      end else begin
        ifu_gnt = ifu_req;
        lsu_gnt = lsu_req;
      end
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (ifu_gnt) begin
      last_grant_d = OWN_IFU;
    end else if (lsu_gnt) begin
      last_grant_d = OWN_LSU;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= OWN_IFU;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/ysyx_25040118_mem_arbiter.sv
// rtl/ysyx_25040118_mem_arbiter.sv - shares one memory port between IFU and LSU with timeout abort
module ysyx_25040118_mem_arbiter
  import ysyx_25040118_mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_rsp_valid,
  output logic              ifu_rsp_err,
  output logic [DATA_W-1:0] ifu_rdata,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic              lsu_we,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [MASK_W-1:0] lsu_wmask,
  output logic              lsu_rsp_valid,
  output logic              lsu_rsp_err,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [MASK_W-1:0] wmask_q, wmask_d;
  logic              req_valid_q, req_valid_d;
  logic              ifu_rsp_valid_q, ifu_rsp_valid_d, ifu_rsp_err_q, ifu_rsp_err_d;
  logic              lsu_rsp_valid_q, lsu_rsp_valid_d, lsu_rsp_err_q, lsu_rsp_err_d;
  logic [DATA_W-1:0] ifu_rdata_q, ifu_rdata_d, lsu_rdata_q, lsu_rdata_d;
  logic              ifu_gnt, lsu_gnt, rsp_fire, abort;

  // Readies are suppressed while reset is held so that every output reads 0.
  ysyx_25040118_rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .en      (rst && (state_q == IDLE)),
    .ifu_req (ifu_req_valid),
    .lsu_req (lsu_req_valid),
    .ifu_gnt (ifu_gnt),
    .lsu_gnt (lsu_gnt)
  );

  assign ifu_req_ready = ifu_gnt;
  assign lsu_req_ready = lsu_gnt;

  always_comb begin
    rsp_fire        = (state_q == WAIT) && mem_rsp_valid;
    abort           = ((state_q == REQ) || (state_q == WAIT)) && !rsp_fire && (cnt_q == CNT_LAST);
    state_d         = state_q;
    owner_d         = owner_q;
    cnt_d           = cnt_q;
    addr_d          = addr_q;
    we_d            = we_q;
    wdata_d         = wdata_q;
    wmask_d         = wmask_q;
    req_valid_d     = req_valid_q;
    ifu_rsp_valid_d = 1'b0;
    ifu_rsp_err_d   = 1'b0;
    ifu_rdata_d     = ifu_rdata_q;
    lsu_rsp_valid_d = 1'b0;
    lsu_rsp_err_d   = 1'b0;
    lsu_rdata_d     = lsu_rdata_q;
    case (state_q)
      IDLE: begin
        if (ifu_req_valid && ifu_gnt) begin
          addr_d = ifu_addr; we_d = 1'b0; wdata_d = '0; wmask_d = MASK_NONE;
          owner_d = OWN_IFU; cnt_d = '0; state_d = REQ; req_valid_d = 1'b1;
        end else if (lsu_req_valid && lsu_gnt) begin
          addr_d = lsu_addr; we_d = lsu_we; wdata_d = lsu_wdata;
          wmask_d = lsu_we ? lsu_wmask : MASK_NONE;
          owner_d = OWN_LSU; cnt_d = '0; state_d = REQ; req_valid_d = 1'b1;
        end
      end
      REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_req_ready) begin
          state_d     = WAIT;
          req_valid_d = 1'b0;
        end
      end
      WAIT: cnt_d = cnt_q + 1'b1;
      default: state_d = IDLE;
    endcase
    // A timeout wins over a request handshake landing in the same cycle.
    if (rsp_fire || abort) begin
      state_d     = IDLE;
      req_valid_d = 1'b0;
      if (owner_q == OWN_IFU) begin
        ifu_rsp_valid_d = 1'b1;
        ifu_rsp_err_d   = abort;
        ifu_rdata_d     = (abort || we_q) ? '0 : mem_rdata;
      end else begin
        lsu_rsp_valid_d = 1'b1;
        lsu_rsp_err_d   = abort;
        lsu_rdata_d     = (abort || we_q) ? '0 : mem_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      owner_q         <= OWN_IFU;
      cnt_q           <= '0;
      addr_q          <= '0;
      we_q            <= 1'b0;
      wdata_q         <= '0;
      wmask_q         <= MASK_NONE;
      req_valid_q     <= 1'b0;
      ifu_rsp_valid_q <= 1'b0;
      ifu_rsp_err_q   <= 1'b0;
      ifu_rdata_q     <= '0;
      lsu_rsp_valid_q <= 1'b0;
      lsu_rsp_err_q   <= 1'b0;
      lsu_rdata_q     <= '0;
    end else begin
      state_q         <= state_d;
      owner_q         <= owner_d;
      cnt_q           <= cnt_d;
      addr_q          <= addr_d;
      we_q            <= we_d;
      wdata_q         <= wdata_d;
      wmask_q         <= wmask_d;
      req_valid_q     <= req_valid_d;
      ifu_rsp_valid_q <= ifu_rsp_valid_d;
      ifu_rsp_err_q   <= ifu_rsp_err_d;
      ifu_rdata_q     <= ifu_rdata_d;
      lsu_rsp_valid_q <= lsu_rsp_valid_d;
      lsu_rsp_err_q   <= lsu_rsp_err_d;
      lsu_rdata_q     <= lsu_rdata_d;
    end
  end

  assign mem_req_valid = req_valid_q;
  assign mem_we        = we_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;
  assign ifu_rsp_valid = ifu_rsp_valid_q;
  assign ifu_rsp_err   = ifu_rsp_err_q;
  assign ifu_rdata     = ifu_rdata_q;
  assign lsu_rsp_valid = lsu_rsp_valid_q;
  assign lsu_rsp_err   = lsu_rsp_err_q;
  assign lsu_rdata     = lsu_rdata_q;

endmodule

// File: tb/tb_ysyx_25040118_mem_arbiter.sv
// tb/tb_ysyx_25040118_mem_arbiter.sv - scoreboard bench for the IFU/LSU memory arbiter
module tb_ysyx_25040118_mem_arbiter;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ifu_req_valid = 1'b0, lsu_req_valid = 1'b0, lsu_we = 1'b0;
  logic [31:0] ifu_addr = '0, lsu_addr = '0, lsu_wdata = '0;
  logic [3:0]  lsu_wmask = '0;
  logic        ifu_req_ready, ifu_rsp_valid, ifu_rsp_err;
  logic        lsu_req_ready, lsu_rsp_valid, lsu_rsp_err;
  logic [31:0] ifu_rdata, lsu_rdata;
  logic        mem_req_valid, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_req_ready = 1'b0, rsp_drv = 1'b0, stray = 1'b0, mem_rsp_valid;
  logic [31:0] mem_rdata = '0;
  logic [139:0] outs;

  typedef struct packed {
    logic        is_lsu;
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  rsp_t exp_q[$];
  int n_chk = 0, n_fail = 0;
  bit mute = 1'b0, pending = 1'b0;
  int stall_cycles = 0, stall_cnt = 0;
  logic [31:0] pend_data = '0;

  assign mem_rsp_valid = rsp_drv | stray;
  assign outs = {ifu_req_ready, ifu_rsp_valid, ifu_rsp_err, ifu_rdata,
                 lsu_req_ready, lsu_rsp_valid, lsu_rsp_err, lsu_rdata,
                 mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask};

  always #5 clk = ~clk;

  ysyx_25040118_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_err(ifu_rsp_err), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_we(lsu_we),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_err(lsu_rsp_err), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] rd_val(input logic [31:0] a);
    return (a == 32'h8000_0000) ? 32'h0000_0413 : (a ^ 32'h5A5A_5A5A);
  endfunction

  // Memory model: optional stall on request acceptance, response one cycle after acceptance.
  always @(negedge clk) begin
    rsp_drv       = 1'b0;
    mem_req_ready = 1'b0;
    mem_rdata     = $urandom;
    if (pending) begin
      pending = 1'b0;
      if (!mute) begin
        rsp_drv   = 1'b1;
        mem_rdata = pend_data;
      end
    end
    if (mem_req_valid) begin
      if (stall_cnt < stall_cycles) begin
        stall_cnt++;
      end else begin
        mem_req_ready = 1'b1;
        pending       = 1'b1;
        pend_data     = mem_we ? 32'h0 : rd_val(mem_addr);
        stall_cnt     = 0;
      end
    end else begin
      stall_cnt = 0;
    end
  end

  // Scoreboard: every response strobe must match the oldest expected entry.
  always @(negedge clk) begin : monitor
    rsp_t        e;
    logic [33:0] got_v;
    if (ifu_req_valid && lsu_req_valid) begin
      n_chk++;
      if (ifu_req_ready && lsu_req_ready) begin
        n_fail++;
        $display("FAIL dual_ready ifu_ready=%b lsu_ready=%b required not both 1", ifu_req_ready, lsu_req_ready);
      end
    end
    if (ifu_rsp_valid || lsu_rsp_valid) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rsp_unexpected ifu_v=%b lsu_v=%b required no response", ifu_rsp_valid, lsu_rsp_valid);
      end else begin
        e = exp_q.pop_front();
        got_v = {ifu_rsp_valid, lsu_rsp_valid};
        got_v = {got_v[1:0], e.is_lsu ? {lsu_rsp_err, lsu_rdata} : {ifu_rsp_err, ifu_rdata}};
        if ({ifu_rsp_valid, lsu_rsp_valid, e.is_lsu ? lsu_rsp_err : ifu_rsp_err,
             e.is_lsu ? lsu_rdata : ifu_rdata} !== {!e.is_lsu, e.is_lsu, e.err, e.rdata}) begin
          n_fail++;
          $display("FAIL rsp_scoreboard ifu_v=%b lsu_v=%b err=%b rdata=%h required lsu=%b err=%b rdata=%h",
                   ifu_rsp_valid, lsu_rsp_valid, got_v[32], got_v[31:0], e.is_lsu, e.err, e.rdata);
        end
      end
    end
  end

  task automatic send(input bit lsu, input bit we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] wmask);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    if (lsu) begin
      lsu_req_valid = 1'b1; lsu_we = we; lsu_addr = addr; lsu_wdata = wdata; lsu_wmask = wmask;
    end else begin
      ifu_req_valid = 1'b1; ifu_addr = addr;
    end
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (lsu ? lsu_req_ready : ifu_req_ready) begin
        got = 1'b1;
        exp_q.push_back({lsu, 1'b0, we ? 32'h0 : rd_val(addr)});
      end
    end
    @(posedge clk); #1;
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    if (!got) begin
      n_chk++; n_fail++;
      $display("FAIL send_ready_timeout lsu=%b addr=%h required ready within 40 cycles", lsu, addr);
    end
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain pending=%0d required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset;
    ifu_req_valid = 1'b1;
    lsu_req_valid = 1'b1;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if (outs !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs outs=%h required 0", outs);
    end
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    n_chk++;
    if (outs !== '0) begin
      n_fail++;
      $display("FAIL reset_release_outputs outs=%h required 0", outs);
    end
  endtask

  task automatic test_round_robin;
    bit got, who;
    @(posedge clk); #1;
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0010;
    lsu_req_valid = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h8000_2000; lsu_wmask = 4'h0;
    for (int g = 0; g < 3; g++) begin
      got = 1'b0;
      who = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
        @(negedge clk);
        if (ifu_req_ready || lsu_req_ready) begin
          got = 1'b1;
          who = lsu_req_ready;
        end
      end
      n_chk++;
      if (!got || who !== (g != 1)) begin
        n_fail++;
        $display("FAIL rr_grant%0d granted=%b lsu=%b required lsu=%b", g, got, who, (g != 1));
      end
      if (got) exp_q.push_back({who, 1'b0, rd_val(who ? lsu_addr : ifu_addr)});
      @(posedge clk); #1;
    end
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    wait_drain("rr");
  endtask

  task automatic test_ifu_fetch;
    @(posedge clk); #1;
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
    @(negedge clk);
    n_chk++;
    if (ifu_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ifu_ready ready=%b required 1", ifu_req_ready);
    end
    exp_q.push_back({1'b0, 1'b0, 32'h0000_0413});
    @(posedge clk); #1;
    ifu_req_valid = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({mem_req_valid, mem_we, mem_addr, mem_wmask} !== {1'b1, 1'b0, 32'h8000_0000, 4'h0}) begin
      n_fail++;
      $display("FAIL ifu_mem_req valid=%b we=%b addr=%h mask=%h required 1 0 80000000 0",
               mem_req_valid, mem_we, mem_addr, mem_wmask);
    end
    @(negedge clk);
    n_chk++;
    if (ifu_rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ifu_rsp_early valid=%b required 0", ifu_rsp_valid);
    end
    @(negedge clk);
    n_chk++;
    if ({ifu_rsp_valid, ifu_rsp_err, ifu_rdata} !== {1'b1, 1'b0, 32'h0000_0413}) begin
      n_fail++;
      $display("FAIL ifu_latency valid=%b err=%b rdata=%h required 1 0 00000413",
               ifu_rsp_valid, ifu_rsp_err, ifu_rdata);
    end
    @(negedge clk);
    n_chk++;
    if ({ifu_rsp_valid, ifu_rdata} !== {1'b0, 32'h0000_0413}) begin
      n_fail++;
      $display("FAIL ifu_hold valid=%b rdata=%h required 0 00000413", ifu_rsp_valid, ifu_rdata);
    end
  endtask

  task automatic test_lsu_store;
    @(posedge clk); #1;
    lsu_req_valid = 1'b1; lsu_we = 1'b1; lsu_addr = 32'h8000_1004;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'b0011;
    @(negedge clk);
    n_chk++;
    if (lsu_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL store_ready ready=%b required 1", lsu_req_ready);
    end
    exp_q.push_back({1'b1, 1'b0, 32'h0});
    @(posedge clk); #1;
    lsu_req_valid = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask} !==
        {1'b1, 1'b1, 32'h8000_1004, 32'hDEAD_BEEF, 4'b0011}) begin
      n_fail++;
      $display("FAIL store_mem_req valid=%b we=%b addr=%h wdata=%h mask=%b required 1 1 80001004 deadbeef 0011",
               mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask);
    end
    wait_drain("store");
    n_chk++;
    if ({lsu_rsp_valid, lsu_rdata} !== {1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL store_rdata valid=%b rdata=%h required 0 00000000", lsu_rsp_valid, lsu_rdata);
    end
  endtask

  task automatic test_stall;
    stall_cycles = 5;
    @(posedge clk); #1;
    lsu_req_valid = 1'b1; lsu_we = 1'b1; lsu_addr = 32'h8000_3008;
    lsu_wdata = 32'h1234_5678; lsu_wmask = 4'b1100;
    @(negedge clk);
    n_chk++;
    if (lsu_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_ready ready=%b required 1", lsu_req_ready);
    end
    exp_q.push_back({1'b1, 1'b0, 32'h0});
    @(posedge clk); #1;
    lsu_req_valid = 1'b0;
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0020;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      n_chk++;
      if ({mem_req_valid, mem_addr, mem_wdata, mem_wmask, ifu_req_ready, lsu_req_ready} !==
          {(k <= 6), 32'h8000_3008, 32'h1234_5678, 4'b1100, 2'b00}) begin
        n_fail++;
        $display("FAIL stall_stable%0d valid=%b addr=%h wdata=%h mask=%b rdy=%b%b required %b 80003008 12345678 1100 00",
                 k, mem_req_valid, mem_addr, mem_wdata, mem_wmask, ifu_req_ready, lsu_req_ready, (k <= 6));
      end
    end
    @(negedge clk);
    n_chk++;
    if ({lsu_rsp_valid, ifu_req_ready} !== 2'b11) begin
      n_fail++;
      $display("FAIL stall_back_to_back lsu_rsp=%b ifu_ready=%b required 1 1", lsu_rsp_valid, ifu_req_ready);
    end
    if (ifu_req_ready) exp_q.push_back({1'b0, 1'b0, rd_val(32'h8000_0020)});
    @(posedge clk); #1;
    ifu_req_valid = 1'b0;
    stall_cycles = 0;
    wait_drain("stall");
  endtask

  task automatic test_timeout;
    int seen;
    mute = 1'b1;
    stall_cycles = 1000;
    @(posedge clk); #1;
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0040;
    @(negedge clk);
    n_chk++;
    if (ifu_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_ready ready=%b required 1", ifu_req_ready);
    end
    exp_q.push_back({1'b0, 1'b1, 32'h0});
    @(posedge clk); #1;
    ifu_req_valid = 1'b0;
    for (int k = 1; k <= T; k++) begin
      @(negedge clk);
      n_chk++;
      if ({ifu_rsp_valid, mem_req_valid} !== 2'b01) begin
        n_fail++;
        $display("FAIL timeout_early%0d rsp=%b req_valid=%b required 0 1", k, ifu_rsp_valid, mem_req_valid);
      end
    end
    @(negedge clk);
    n_chk++;
    if ({ifu_rsp_valid, ifu_rsp_err, ifu_rdata, mem_req_valid} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL timeout_abort rsp=%b err=%b rdata=%h req_valid=%b required 1 1 00000000 0",
               ifu_rsp_valid, ifu_rsp_err, ifu_rdata, mem_req_valid);
    end
    @(posedge clk); #1;
    stray = 1'b1;
    @(posedge clk); #1;
    stray = 1'b0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (ifu_rsp_valid || lsu_rsp_valid) seen++;
    end
    n_chk++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL timeout_stray responses=%0d required 0", seen);
    end
    mute = 1'b0;
    stall_cycles = 0;
  endtask

  task automatic test_reset_mid;
    int seen;
    mute = 1'b1;
    @(posedge clk); #1;
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0060;
    @(negedge clk);
    n_chk++;
    if (ifu_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_ready ready=%b required 1", ifu_req_ready);
    end
    @(posedge clk); #1;
    ifu_req_valid = 1'b0;
    repeat (2) @(negedge clk);
    ifu_req_valid = 1'b1;
    rst = 1'b0;
    #1;
    n_chk++;
    if (outs !== '0) begin
      n_fail++;
      $display("FAIL rstmid_async outs=%h required 0", outs);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    ifu_req_valid = 1'b0;
    mute = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (ifu_rsp_valid || lsu_rsp_valid) seen++;
    end
    n_chk++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL rstmid_no_rsp responses=%0d required 0", seen);
    end
    send(1'b0, 1'b0, 32'h8000_0070, 32'h0, 4'h0);
    wait_drain("rstmid");
    n_chk++;
    if (ifu_rdata !== rd_val(32'h8000_0070)) begin
      n_fail++;
      $display("FAIL rstmid_recover rdata=%h required %h", ifu_rdata, rd_val(32'h8000_0070));
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_ifu_fetch();
    test_lsu_store();
    test_stall();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1);
  end

endmodule

// File: doc/ysyx_25040118_mem_arbiter.md
Name: ysyx_25040118_mem_arbiter

Overview:
- Shares the single physical memory port between the IFU (instruction fetch, read-only) and the LSU (load/store, read/write with byte mask) in the multi-cycle NPC.
- Accepts at most one transaction at a time and forwards it to memory over a valid/ready request channel plus a response strobe.
- Routes the response back to the issuing requester.
- Arbitrates simultaneous requests round-robin and aborts hung transactions with an error response after a timeout.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 255, max cycles in REQ+WAIT before abort; must be ≥2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (rst=0 resets).
- ifu_req_valid  in  1  IFU read request.
- ifu_req_ready  out  1  IFU request accepted this cycle.
- ifu_addr  in  ADDR_W  IFU fetch address.
- ifu_rsp_valid  out  1  one-cycle IFU response strobe.
- ifu_rsp_err  out  1  IFU response is a timeout abort.
- ifu_rdata  out  DATA_W  fetched word.
- lsu_req_valid  in  1  LSU request.
- lsu_req_ready  out  1  LSU request accepted this cycle.
- lsu_we  in  1  1=store, 0=load.
- lsu_addr  in  ADDR_W  LSU address.
- lsu_wdata  in  DATA_W  store data.
- lsu_wmask  in  4  store byte mask.
- lsu_rsp_valid  out  1  one-cycle LSU response (load data or store ack).
- lsu_rsp_err  out  1  LSU response is a timeout abort.
- lsu_rdata  out  DATA_W  load word (0 for stores).
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepts request.
- mem_we  out  1  write enable.
- mem_addr  out  ADDR_W  address.
- mem_wdata  out  DATA_W  write data.
- mem_wmask  out  4  write mask (0 for reads).
- mem_rsp_valid  in  1  memory response strobe.
- mem_rdata  in  DATA_W  read data.

Behaviour:
- States:
  - IDLE: no transaction held.
  - REQ: mem_req_valid=1, request not yet accepted.
  - WAIT: request accepted, awaiting mem_rsp_valid.
- Reset (rst=0, async):
  - state=IDLE, owner=none, last_grant=IFU, timeout counter=0.
  - All outputs 0: *_ready, *_rsp_valid, *_rsp_err, *_rdata, all mem_* outputs.
- IDLE arbitration (combinational readies):
  - Only one valid → that requester gets ready=1.
  - Both valid → grant the requester not equal to last_grant. First tie after reset goes to LSU.
  - *_req_ready is never 1 outside IDLE and never for both requesters in the same cycle.
- Accept (valid&&ready at edge):
  - Latch addr, we, wdata, wmask (IFU: we=0, wmask=0), owner, last_grant←owner.
  - Counter←0; next state REQ.
- REQ:
  - mem_* driven from latches only; they stay stable until accepted.
  - mem_req_valid&&mem_req_ready → WAIT.
  - mem_rsp_valid in REQ is ignored.
- WAIT:
  - mem_rsp_valid → the next cycle, the owner's rsp_valid=1 for exactly one cycle, rsp_err=0.
  - rdata registered: mem_rdata for reads, 0 for writes.
  - State returns to IDLE in that same cycle, so a new accept may occur.
- Latency:
  - Accept at cycle N; mem_req_valid at N+1.
  - mem_req_ready at N+1 → WAIT at N+2.
  - mem_rsp_valid at cycle M → rsp_valid at M+1.
  - Minimum accept-to-response: 3 cycles.
- Timeout:
  - Counter increments each cycle in REQ or WAIT.
  - At count==TIMEOUT-1 with no response: owner rsp_valid=1, rsp_err=1, rdata=0; mem_req_valid drops; state→IDLE.
  - A stray mem_rsp_valid later arriving in IDLE is ignored.
- Response hold: *_rdata holds its last value until the next response; rsp_valid and rsp_err are single-cycle pulses.
- Reset mid-transaction: transaction dropped silently; no response is issued.
- Arithmetic: counter width $clog2(TIMEOUT+1); saturation is not needed because timeout forces IDLE.

Decomposition:
- Shared package ysyx_25040118_mem_pkg holds:
  - state enum {IDLE, REQ, WAIT}
  - owner enum {OWN_IFU, OWN_LSU}
  - constants: mask width 4, MASK_NONE=4'b0000, MASK_WORD=4'b1111
- One natural sub-module: ysyx_25040118_rr_arb2, a 2-way round-robin grant with a last_grant register.

Test Plan:
- IFU alone, addr=0x80000000:
  - ready in cycle N; mem_addr=0x80000000, mem_we=0 at N+1.
  - Memory returns 0x00000413 one cycle after accept → ifu_rsp_valid pulse, ifu_rdata=0x00000413, err=0.
- LSU store, addr=0x80001004, wdata=0xDEADBEEF, wmask=4'b0011:
  - mem_we=1, mem_wmask=4'b0011, mem_wdata=0xDEADBEEF.
  - Response → lsu_rsp_valid=1, lsu_rdata=0.
- Simultaneous valids from reset:
  - First grant is LSU; second tie is IFU; third tie is LSU.
  - The two readies are never high together.
- mem_req_ready held 0 for 5 cycles: mem_addr, mem_wdata and mem_wmask stable throughout; no *_req_ready during REQ/WAIT.
- TIMEOUT=8, memory never responds:
  - rsp_valid=1, err=1, rdata=0 exactly 8 cycles after entering REQ.
  - A later mem_rsp_valid produces no response.
- rst=0 asserted in WAIT: outputs 0 immediately (async); no rsp_valid after release; next IFU request is served normally.
